// File: rtl/regfile_writeback_if.sv
// Bus between the SEQ datapath and the register file / write-back block.
// master: execute/memory/decode side; slave: regfile_writeback.
interface regfile_writeback_if #(
  parameter int DATA_W = 64
);
  logic [3:0]        icode;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic              Cnd;
  logic [1:0]        stat;
  logic [DATA_W-1:0] valE;
  logic [DATA_W-1:0] valM;
  logic [3:0]        srcA;
  logic [3:0]        srcB;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic              halted;

  modport master (
    output icode, rA, rB, Cnd, stat, valE, valM, srcA, srcB,
    input  valA, valB, halted
  );

  modport slave (
    input  icode, rA, rB, Cnd, stat, valE, valM, srcA, srcB,
    output valA, valB, halted
  );
endinterface

// File: rtl/regfile_writeback.sv
// Y86-64 SEQ register file with write-back stage and sticky halt latch.
// Two combinational read ports (srcA/srcB -> valA/valB), one E and one M
// write per edge; an M write overrides an E write to the same register.
// Optional feature: define REGFILE_BYPASS_EN to forward the pending write
// values onto the read ports.
module regfile_writeback #(
  parameter int          DATA_W  = 64,
  parameter int unsigned NREG    = 15,
  parameter int unsigned RSP_IDX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_writeback_if.slave   bus
);

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] regs [NREG];
  logic [3:0]        dstE, dstM;
  logic              we;

  // Destination decode from the retiring instruction
  always_comb begin
    dstE = RNONE;
    dstM = RNONE;
    unique case (bus.icode)
      4'h2:                      dstE = bus.Cnd ? bus.rB : RNONE;
      4'h3, 4'h6:                dstE = bus.rB;
      4'h8, 4'h9, 4'hA, 4'hB:    dstE = 4'(RSP_IDX);
      default:                   dstE = RNONE;
    endcase
    if (bus.icode == 4'h5 || bus.icode == 4'hB)
      dstM = bus.rA;
  end

  // Reset is folded in so forwarding never shows pending data while held in reset
  assign we = (bus.stat == 2'd0) && (state == RUN) && rst_n;

  // Halt state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Next-state: any non-AOK retirement halts permanently until reset
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (bus.stat != 2'd0) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  assign bus.halted = (state == HALT);

  // Register array write-back; M branch first so it wins a dstE==dstM conflict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (dstM == 4'(i))      regs[i] <= bus.valM;
        else if (dstE == 4'(i)) regs[i] <= bus.valE;
      end
    end
  end

  // Read ports; RNONE matches no entry and reads zero
  always_comb begin
    bus.valA = '0;
    bus.valB = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (bus.srcA == 4'(i)) bus.valA = regs[i];
      if (bus.srcB == 4'(i)) bus.valB = regs[i];
    end
`ifdef REGFILE_BYPASS_EN
    // E forwarding applied first so M overrides it, matching write priority
    if (we && dstE != RNONE && bus.srcA == dstE) bus.valA = bus.valE;
    if (we && dstE != RNONE && bus.srcB == dstE) bus.valB = bus.valE;
    if (we && dstM != RNONE && bus.srcA == dstM) bus.valA = bus.valM;
    if (we && dstM != RNONE && bus.srcB == dstM) bus.valB = bus.valM;
`endif
  end

endmodule
